// File: rtl/shotavg_acc_if.sv
// Stream input, host read port and status signals of shotavg_acc.
// The master modport is the upstream/host side; the slave modport is the accumulator.
interface shotavg_acc_if #(
    parameter int DATAWIDTH = 32,
    parameter int SUMWIDTH  = 48,
    parameter int ADDRWIDTH = 9
);
    logic                        shot_start;
    logic                        first_shot;
    logic                        in_stb;
    logic signed [DATAWIDTH-1:0] in_x;
    logic signed [DATAWIDTH-1:0] in_y;
    logic [ADDRWIDTH-1:0]        rd_addr;
    logic [2*SUMWIDTH-1:0]       rd_data;
    logic                        clr_flags;
    logic [ADDRWIDTH:0]          nbins;
    logic                        busy;
    logic                        ovf;
    logic                        overrun;

    modport master (
        output shot_start, first_shot, in_stb, in_x, in_y, rd_addr, clr_flags,
        input  rd_data, nbins, busy, ovf, overrun
    );

    modport slave (
        input  shot_start, first_shot, in_stb, in_x, in_y, rd_addr, clr_flags,
        output rd_data, nbins, busy, ovf, overrun
    );
endinterface

// File: rtl/shotavg_acc.sv
// Multi-shot (accx, accy) accumulator: 3-stage read-modify-write into a dual-port bin RAM.
// Define SHOTAVG_SAT_EN to saturate sums on overflow; otherwise sums wrap.
module shotavg_acc #(
    parameter int DATAWIDTH = 32,
    parameter int SUMWIDTH  = 48,
    parameter int ADDRWIDTH = 9
) (
    input  logic         clk,
    input  logic         reset,
    shotavg_acc_if.slave bus
);
    localparam int NBINS = 2**ADDRWIDTH;
    localparam int SW1   = SUMWIDTH + 1;

    typedef logic signed [SUMWIDTH-1:0] sum_t;
    typedef enum logic {MODE_ACC = 1'b0, MODE_OVR = 1'b1} mode_e;

    logic [2*SUMWIDTH-1:0] mem [NBINS];

    logic [ADDRWIDTH:0]    wptr;
    mode_e                 mode;

    logic                  s0_vld;
    logic [ADDRWIDTH-1:0]  s0_addr;
    mode_e                 s0_mode;
    logic                  drop;

    logic                        s1_vld;
    logic [ADDRWIDTH-1:0]        s1_addr;
    logic signed [DATAWIDTH-1:0] s1_x, s1_y;
    mode_e                       s1_mode;
    logic [2*SUMWIDTH-1:0]       ram_q;
    logic [2*SUMWIDTH-1:0]       fwd;

    logic                        s2_vld;
    logic [ADDRWIDTH-1:0]        s2_addr;
    logic signed [DATAWIDTH-1:0] s2_x, s2_y;
    mode_e                       s2_mode;
    sum_t                        s2_old_x, s2_old_y;
    sum_t                        new_x, new_y;
    logic                        ov_x, ov_y;
    logic [2*SUMWIDTH-1:0]       wdata;

    logic                        w1_vld;
    logic [ADDRWIDTH-1:0]        w1_addr;
    logic [2*SUMWIDTH-1:0]       w1_data;

    function automatic sum_t combine(input sum_t old, input logic signed [DATAWIDTH-1:0] din,
                                     input mode_e m, output logic ov);
        logic signed [SW1-1:0] ext;
        logic signed [SW1-1:0] sum;
        sum_t                  res;
        ext = SW1'(din);
        sum = SW1'(old) + ext;
        ov  = 1'b0;
        res = sum[SUMWIDTH-1:0];
        if (m == MODE_OVR) begin
            res = ext[SUMWIDTH-1:0];
        end else begin
            ov = sum[SW1-1] ^ sum[SW1-2];
`ifdef SHOTAVG_SAT_EN
            if (ov) begin
                res = sum[SW1-1] ? {1'b1, {(SUMWIDTH-1){1'b0}}} : {1'b0, {(SUMWIDTH-1){1'b1}}};
            end
`endif
        end
        return res;
    endfunction

    // A strobe coincident with shot_start belongs to the new shot: bin 0, new mode.
    always_comb begin
        s0_vld  = 1'b0;
        drop    = 1'b0;
        s0_addr = wptr[ADDRWIDTH-1:0];
        s0_mode = mode;
        if (bus.shot_start) begin
            s0_addr = '0;
            s0_mode = bus.first_shot ? MODE_OVR : MODE_ACC;
        end
        if (bus.in_stb) begin
            if (bus.shot_start || !wptr[ADDRWIDTH]) s0_vld = 1'b1;
            else                                    drop   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr      <= '0;
            mode      <= MODE_OVR;
            bus.nbins <= '0;
        end else if (bus.shot_start) begin
            bus.nbins <= wptr;
            mode      <= s0_mode;
            wptr      <= {{ADDRWIDTH{1'b0}}, s0_vld};
        end else if (s0_vld) begin
            wptr <= wptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        ram_q <= mem[s0_addr];
        if (s2_vld) mem[s2_addr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bus.rd_data <= '0;
        else        bus.rd_data <= mem[bus.rd_addr];
    end

    // S2's pending write beats the write committed a cycle earlier, which beats RAM data.
    always_comb begin
        fwd = ram_q;
        if (s2_vld && (s2_addr == s1_addr))      fwd = wdata;
        else if (w1_vld && (w1_addr == s1_addr)) fwd = w1_data;
    end

    always_comb begin
        new_x = combine(s2_old_x, s2_x, s2_mode, ov_x);
        new_y = combine(s2_old_y, s2_y, s2_mode, ov_y);
        wdata = {new_x, new_y};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld   <= 1'b0;
            s1_addr  <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_mode  <= MODE_OVR;
            s2_vld   <= 1'b0;
            s2_addr  <= '0;
            s2_x     <= '0;
            s2_y     <= '0;
            s2_mode  <= MODE_OVR;
            s2_old_x <= '0;
            s2_old_y <= '0;
            w1_vld   <= 1'b0;
            w1_addr  <= '0;
            w1_data  <= '0;
        end else begin
            s1_vld   <= s0_vld;
            s1_addr  <= s0_addr;
            s1_x     <= bus.in_x;
            s1_y     <= bus.in_y;
            s1_mode  <= s0_mode;
            s2_vld   <= s1_vld;
            s2_addr  <= s1_addr;
            s2_x     <= s1_x;
            s2_y     <= s1_y;
            s2_mode  <= s1_mode;
            s2_old_x <= fwd[2*SUMWIDTH-1:SUMWIDTH];
            s2_old_y <= fwd[SUMWIDTH-1:0];
            w1_vld   <= s2_vld;
            w1_addr  <= s2_addr;
            w1_data  <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.ovf     <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            bus.ovf     <= (s2_vld && (ov_x || ov_y)) || (bus.ovf && !bus.clr_flags);
            bus.overrun <= drop || (bus.overrun && !bus.clr_flags);
        end
    end

    assign bus.busy = s0_vld | s1_vld | s2_vld;

endmodule

// File: tb/tb_shotavg_acc.sv
// Scoreboarded bench for shotavg_acc: directed scenarios plus randomized shots against a bin-array model.
module tb_shotavg_acc;
    localparam int DW = 32;
    localparam int SW = 32;
    localparam int AW = 2;
    localparam int NB = 2**AW;

    logic clk;
    logic reset;

    shotavg_acc_if #(.DATAWIDTH(DW), .SUMWIDTH(SW), .ADDRWIDTH(AW)) bus ();

    shotavg_acc #(.DATAWIDTH(DW), .SUMWIDTH(SW), .ADDRWIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          addr;
        logic [63:0] exp;
    } rd_item_t;
    rd_item_t sbq[$];
    logic rd_req = 1'b0;
    logic rd_vld = 1'b0;

    // reference model: bins as plain arrays, shot bookkeeping as integers
    logic [SW-1:0] mx [NB];
    logic [SW-1:0] my [NB];
    int  m_wptr = 0;
    int  m_nbins = 0;
    bit  m_mode_ovr = 1'b1;
    bit  m_ovf = 1'b0;
    bit  m_overrun = 1'b0;
    bit  model_en = 1'b1;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] acc_fn(input logic [SW-1:0] old, input logic [DW-1:0] x,
                                            input bit ovr, output bit ov);
        longint o, i, s, hi, lo;
        o  = $signed(old);
        i  = $signed(x);
        hi = (longint'(1) <<< (SW-1)) - 1;
        lo = -(longint'(1) <<< (SW-1));
        s  = ovr ? i : o + i;
        ov = 1'b0;
        if (s > hi || s < lo) begin
            ov = 1'b1;
`ifdef SHOTAVG_SAT_EN
            s = (s > hi) ? hi : lo;
`endif
        end
        return s[SW-1:0];
    endfunction

    task automatic model_step(input bit ss, input bit fs, input bit stb,
                              input logic [DW-1:0] x, input logic [DW-1:0] y, input bit clr);
        bit ovx, ovy;
        if (!model_en) return;
        if (clr) begin
            m_ovf = 1'b0;
            m_overrun = 1'b0;
        end
        if (ss) begin
            m_nbins = m_wptr;
            m_wptr = 0;
            m_mode_ovr = fs;
        end
        if (stb) begin
            if (m_wptr < NB) begin
                mx[m_wptr] = acc_fn(mx[m_wptr], x, m_mode_ovr, ovx);
                my[m_wptr] = acc_fn(my[m_wptr], y, m_mode_ovr, ovy);
                if (ovx || ovy) m_ovf = 1'b1;
                m_wptr++;
            end else begin
                m_overrun = 1'b1;
            end
        end
    endtask

    task automatic cyc(input bit ss, input bit fs, input bit stb,
                       input logic [DW-1:0] x, input logic [DW-1:0] y, input bit clr);
        bus.shot_start = ss;
        bus.first_shot = fs;
        bus.in_stb     = stb;
        bus.in_x       = x;
        bus.in_y       = y;
        bus.clr_flags  = clr;
        model_step(ss, fs, stb, x, y, clr);
        @(posedge clk);
        #1;
        bus.shot_start = 1'b0;
        bus.in_stb     = 1'b0;
        bus.clr_flags  = 1'b0;
    endtask

    task automatic rd(input int a, input logic [63:0] exp);
        rd_item_t it;
        logic [31:0] av;
        av = a;
        it.addr = a;
        it.exp  = exp;
        sbq.push_back(it);
        bus.rd_addr = av[AW-1:0];
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic rd_model(input int a);
        rd(a, {mx[a], my[a]});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (bus.busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_idle", {63'd0, bus.busy}, 64'd0);
    endtask

    function automatic logic [31:0] rv();
        if (($urandom % 8) == 0) return $urandom;
        return 32'($urandom_range(0, 2000)) - 32'd1000;
    endfunction

    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        rd_item_t it;
        if (rd_vld) begin
            if (sbq.size() == 0) begin
                check("rd_unexpected", 64'd1, 64'd0);
            end else begin
                it = sbq.pop_front();
                check($sformatf("rd_bin%0d", it.addr), bus.rd_data, it.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        bit fs, same;
        int nshots, nstb, k0;

        reset = 1'b0;
        bus.shot_start = 1'b0;
        bus.first_shot = 1'b0;
        bus.in_stb     = 1'b0;
        bus.in_x       = '0;
        bus.in_y       = '0;
        bus.rd_addr    = '0;
        bus.clr_flags  = 1'b0;
        for (int i = 0; i < NB; i++) begin
            mx[i] = '0;
            my[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_data", bus.rd_data, 64'd0);
        check("rst_nbins",   {61'd0, bus.nbins}, 64'd0);
        check("rst_busy",    {63'd0, bus.busy}, 64'd0);
        check("rst_ovf",     {63'd0, bus.ovf}, 64'd0);
        check("rst_overrun", {63'd0, bus.overrun}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // overwrite shot then three accumulate shots
        for (int s = 0; s < 4; s++) begin
            cyc(1'b1, s == 0, 1'b0, '0, '0, 1'b0);
            for (int i = 1; i <= 4; i++) begin
                cyc(1'b0, 1'b0, 1'b1, 32'(i), 32'hFFFF_FFFF, 1'b0);
                if (s == 0 && i == 1) check("busy_active", {63'd0, bus.busy}, 64'd1);
            end
        end
        cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        check("acc_nbins", {61'd0, bus.nbins}, 64'd4);
        drain();
        for (int i = 0; i < 4; i++) rd(i, {32'(4 * (i + 1)), 32'hFFFF_FFFC});

        // 1-bin shots two cycles apart, then every cycle
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, k == 0, 1'b0, '0, '0, 1'b0);
            cyc(1'b0, 1'b0, 1'b1, 32'd5, -32'sd5, 1'b0);
        end
        drain();
        rd(0, {32'd40, -32'sd40});
        for (int k = 0; k < 8; k++) cyc(1'b1, k == 0, 1'b1, 32'd5, -32'sd5, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        check("b2b_nbins", {61'd0, bus.nbins}, 64'd1);
        drain();
        rd(0, {32'd40, -32'sd40});

        // overrun: 6 strobes into 4 bins
        cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        for (int i = 1; i <= 6; i++) cyc(1'b0, 1'b0, 1'b1, 32'(i), 32'(10 * i), 1'b0);
        drain();
        check("overrun_set", {63'd0, bus.overrun}, 64'd1);
        for (int i = 0; i < 4; i++) rd(i, {32'(i + 1), 32'(10 * (i + 1))});
        cyc(1'b0, 1'b0, 1'b1, 32'd7, 32'd7, 1'b1);
        check("overrun_set_wins", {63'd0, bus.overrun}, {63'd0, m_overrun});
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        check("overrun_clr", {63'd0, bus.overrun}, 64'd0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        check("overrun_nbins", {61'd0, bus.nbins}, 64'd4);

        // overflow, positive on x and negative on y
        cyc(1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        drain();
        check("ovf_set", {63'd0, bus.ovf}, 64'd1);
`ifdef SHOTAVG_SAT_EN
        rd(0, {32'h7FFF_FFFF, 32'h8000_0000});
`else
        rd(0, {32'hFFFF_FFFE, 32'h0000_0000});
`endif
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        check("ovf_clr", {63'd0, bus.ovf}, 64'd0);

        // shot_start and strobe in the same cycle
        cyc(1'b0, 1'b0, 1'b1, 32'd3, 32'd3, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'd4, 32'd4, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'd9, -32'sd9, 1'b0);
        check("same_nbins_prev", {61'd0, bus.nbins}, 64'd3);
        cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        check("same_nbins_one", {61'd0, bus.nbins}, 64'd1);
        drain();
        rd(0, {32'd9, -32'sd9});
        for (int i = 1; i < NB; i++) rd_model(i);

        // async reset while a write sits in the last stage
        model_en = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 32'd100, 32'd100, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_rd_data", bus.rd_data, 64'd0);
        check("rstmid_nbins",   {61'd0, bus.nbins}, 64'd0);
        check("rstmid_busy",    {63'd0, bus.busy}, 64'd0);
        check("rstmid_ovf",     {63'd0, bus.ovf}, 64'd0);
        check("rstmid_overrun", {63'd0, bus.overrun}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_en = 1'b1;
        m_wptr = 0;
        m_nbins = 0;
        m_mode_ovr = 1'b1;
        m_ovf = 1'b0;
        m_overrun = 1'b0;
        rd(0, {32'd9, -32'sd9});
        cyc(1'b1, 1'b0, 1'b1, 32'd1, 32'd1, 1'b0);
        check("post_rst_nbins", {61'd0, bus.nbins}, 64'd0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        check("post_rst_restart", {61'd0, bus.nbins}, 64'd1);
        drain();
        rd(0, {32'd10, -32'sd8});

        // randomized shots against the model
        for (int r = 0; r < 30; r++) begin
            nshots = $urandom_range(1, 4);
            for (int s = 0; s < nshots; s++) begin
                fs   = (($urandom % 4) == 0);
                nstb = $urandom_range(0, 6);
                same = (nstb > 0) && (($urandom % 3) == 0);
                cyc(1'b1, fs, same, rv(), rv(), 1'b0);
                k0 = same ? 1 : 0;
                for (int k = k0; k < nstb; k++) begin
                    if (($urandom % 3) == 0) cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
                    cyc(1'b0, 1'b0, 1'b1, rv(), rv(), 1'b0);
                end
            end
            drain();
            cyc(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
            check("rnd_nbins", {61'd0, bus.nbins}, 64'(m_nbins));
            for (int i = 0; i < NB; i++) rd_model(i);
            check("rnd_ovf",     {63'd0, bus.ovf}, {63'd0, m_ovf});
            check("rnd_overrun", {63'd0, bus.overrun}, {63'd0, m_overrun});
            cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        end

        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
